cmd_issue_sched: RTL and testbench
==================================

Name: cmd_issue_sched

Overview:
Scheduler for the single SD CMD-line engine. Two requesters share it: software commands, raised by a write to the Command register, and Auto CMD12, raised by the data-line controller at the end of a multi-block transfer. The block holds at most one pending request per source and arbitrates Auto CMD12 first. It sequences each command through issue, command-sent and response phases, with a watchdog on the response phase. It also drives the Command Inhibit (CMD) status bit and per-source completion pulses.

Parameters:
WatchdogCycles, 4096, clk_i cycles allowed in the response wait before the command is aborted; must be >= 2.
Auto12Index, 12, command index issued for Auto CMD12.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
sw_rst_cmd_i  in  1  synchronous software reset for the CMD line
sw_req_i  in  1  one-cycle pulse on Command-register write
sw_index_i  in  6  software command index
sw_arg_i  in  32  software argument
sw_rsp_type_i  in  2  software response type: 0 none, 1 R136, 2 R48, 3 R48b
auto12_req_i  in  1  one-cycle Auto CMD12 request pulse
cmd_start_o  out  1  one-cycle start strobe to the CMD engine
cmd_index_o  out  6  index of the command in flight
cmd_arg_o  out  32  argument of the command in flight
cmd_rsp_type_o  out  2  response type of the command in flight
cmd_sent_i  in  1  pulse: engine finished transmitting the command
rsp_done_i  in  1  pulse: response received
cmd_inhibit_o  out  1  Command Inhibit (CMD) status bit
auto12_active_o  out  1  high while Auto CMD12 is in flight
sw_done_o  out  1  pulse: software command complete
auto12_done_o  out  1  pulse: Auto CMD12 complete
sw_reject_o  out  1  pulse: software request dropped
watchdog_err_o  out  1  pulse: response watchdog expired

Behaviour:
- Reset, asynchronous or via sw_rst_cmd_i:
  - FSM goes to IDLE; both pending flags, the watchdog counter and all outputs are 0.
  - cmd_index_o, cmd_arg_o and cmd_rsp_type_o are 0.
  - sw_rst_cmd_i takes priority over every other input in the same cycle.
- Pending capture:
  - sw_pend_q is set on sw_req_i when it is clear and no software command is in flight.
  - Otherwise the request produces sw_reject_o for 1 cycle and is dropped.
  - The index, argument and response type are latched into the software slot at capture.
  - auto12_req_i sets a12_pend_q; a repeat request while one is pending or in flight is merged and raises no error.
- cmd_inhibit_o = sw_pend_q | (FSM != IDLE), registered. It is visible the cycle after capture.
- FSM states: IDLE, ISSUE, WAIT_SENT, WAIT_RSP, COMPLETE.
  - IDLE: if a12_pend_q, select auto and go to ISSUE. Else if sw_pend_q, select software and go to ISSUE. Auto CMD12 wins a simultaneous pending.
  - ISSUE: cmd_start_o = 1 for exactly one cycle. Clear the selected pending flag. Go to WAIT_SENT.
  - Auto selection drives index Auto12Index, argument 0 and response type 3.
  - cmd_* outputs are registered at ISSUE entry and held stable until IDLE is re-entered.
  - WAIT_SENT: on cmd_sent_i, go to COMPLETE if the response type is 0, else go to WAIT_RSP and clear the watchdog.
  - WAIT_RSP: the watchdog increments each cycle.
    - On rsp_done_i, go to COMPLETE.
    - When the counter reaches WatchdogCycles-1 without rsp_done_i, pulse watchdog_err_o and go to COMPLETE.
    - If rsp_done_i and expiry occur in the same cycle, rsp_done_i wins and no error is raised.
  - COMPLETE: pulse sw_done_o or auto12_done_o according to the selection. Go to IDLE.
- auto12_active_o = selection is auto and FSM is in ISSUE, WAIT_SENT, WAIT_RSP or COMPLETE.
- Latency: request pulse to cmd_start_o is 2 cycles (capture, then IDLE->ISSUE). cmd_start_o never fires in consecutive cycles.
- A new request arriving during COMPLETE is captured normally and issued after IDLE.
- cmd_sent_i or rsp_done_i arriving in an unexpected state is ignored.
- Watchdog width is clog2(WatchdogCycles). The counter saturates and never wraps.

Decomposition:
- cmd_sched_pkg holds:
  - rsp_type_e {RSP_NONE, RSP_136, RSP_48, RSP_48B}
  - the FSM enum
  - the cmd_slot_t struct {index, arg, rsp_type}
  - the AUTO12_ARG constant
- One sub-module, cmd_watchdog: a saturating counter with clear, enable and expire outputs, parameterised by WatchdogCycles.

Test Plan:
- Software command: sw_req_i with index 17, arg 0x0000_0200, rsp 2 -> cmd_start_o 2 cycles later with the same fields. cmd_sent_i then rsp_done_i -> sw_done_o one cycle after rsp_done_i, cmd_inhibit_o returns to 0.
- Simultaneous requests: auto12_req_i and sw_req_i in the same cycle -> CMD12 issued first with arg 0 and rsp 3, auto12_active_o high. The software command issues after auto12_done_o; sw_done_o follows.
- Reject: second sw_req_i while the first is pending or in flight -> sw_reject_o for 1 cycle, exactly one cmd_start_o for the software source.
- Watchdog: WatchdogCycles=16, rsp 2, no rsp_done_i -> watchdog_err_o exactly 16 cycles after entering WAIT_RSP, then sw_done_o. rsp_done_i on the expiry cycle -> no error.
- No response: rsp 0 -> sw_done_o one cycle after cmd_sent_i, no watchdog activity.
- Mid-operation reset: sw_rst_cmd_i or rst_ni in WAIT_RSP with both sources pending -> all outputs 0 and the FSM in IDLE next cycle. Late rsp_done_i is ignored and produces no done pulse.

Source files
------------

// File: rtl/cmd_sched_pkg.sv
// Shared types for the SD CMD-line issue scheduler: response types, FSM states,
// the command slot layout and the fixed Auto CMD12 argument.
package cmd_sched_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_136  = 2'd1,
    RSP_48   = 2'd2,
    RSP_48B  = 2'd3
  } rsp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_COMPLETE  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    rsp_type_e   rsp_type;
  } cmd_slot_t;

  localparam logic [31:0] AUTO12_ARG = 32'h0000_0000;

  // COMPLETE is deliberately excluded so a source can re-request while its done pulse is out.
  function automatic logic in_flight(sched_state_e s);
    return (s == ST_ISSUE) || (s == ST_WAIT_SENT) || (s == ST_WAIT_RSP);
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating response-wait counter; expire_o is high while the count sits at its last value.
module cmd_watchdog #(
  parameter int unsigned WatchdogCycles = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(WatchdogCycles);
  localparam logic [CntW-1:0] LastCnt = CntW'(WatchdogCycles - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign expire_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_issue_sched.sv
// Arbitrates software commands and Auto CMD12 onto the single CMD engine and
// sequences each through issue, command-sent and response phases.
module cmd_issue_sched
  import cmd_sched_pkg::*;
#(
  parameter int unsigned WatchdogCycles = 4096,
  parameter int unsigned Auto12Index    = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sw_rst_cmd_i,
  input  logic        sw_req_i,
  input  logic [5:0]  sw_index_i,
  input  logic [31:0] sw_arg_i,
  input  logic [1:0]  sw_rsp_type_i,
  input  logic        auto12_req_i,
  output logic        cmd_start_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_rsp_type_o,
  input  logic        cmd_sent_i,
  input  logic        rsp_done_i,
  output logic        cmd_inhibit_o,
  output logic        auto12_active_o,
  output logic        sw_done_o,
  output logic        auto12_done_o,
  output logic        sw_reject_o,
  output logic        watchdog_err_o
);

  localparam logic [5:0] Auto12Idx = 6'(Auto12Index);

  sched_state_e state_q, state_d;
  logic         sel_auto_q, sel_auto_d;
  logic         sw_pend_q, sw_pend_d;
  logic         a12_pend_q, a12_pend_d;
  cmd_slot_t    sw_slot_q, sw_slot_d;
  cmd_slot_t    cmd_q, cmd_d;
  logic         inhibit_q, inhibit_d;
  logic         reject_q, reject_d;
  logic         wd_err_q, wd_err_d;
  logic         wd_clear;
  logic         wd_en;
  logic         wd_expire;
  logic         sw_busy;
  logic         a12_busy;

  cmd_watchdog #(
    .WatchdogCycles(WatchdogCycles)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (wd_clear),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    sel_auto_d = sel_auto_q;
    sw_pend_d  = sw_pend_q;
    a12_pend_d = a12_pend_q;
    sw_slot_d  = sw_slot_q;
    cmd_d      = cmd_q;
    reject_d   = 1'b0;
    wd_err_d   = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    sw_busy    = !sel_auto_q && in_flight(state_q);
    a12_busy   = sel_auto_q && in_flight(state_q);

    if (sw_req_i) begin
      if (sw_pend_q || sw_busy) begin
        reject_d = 1'b1;
      end else begin
        sw_pend_d = 1'b1;
        sw_slot_d = '{index: sw_index_i, arg: sw_arg_i, rsp_type: rsp_type_e'(sw_rsp_type_i)};
      end
    end
    // A repeat Auto CMD12 while one is pending or running folds into it silently.
    if (auto12_req_i && !a12_busy) begin
      a12_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (a12_pend_q) begin
          sel_auto_d = 1'b1;
          cmd_d      = '{index: Auto12Idx, arg: AUTO12_ARG, rsp_type: RSP_48B};
          state_d    = ST_ISSUE;
        end else if (sw_pend_q) begin
          sel_auto_d = 1'b0;
          cmd_d      = sw_slot_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sel_auto_q) begin
          a12_pend_d = 1'b0;
        end else begin
          sw_pend_d = 1'b0;
        end
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (cmd_sent_i) begin
          if (cmd_q.rsp_type == RSP_NONE) begin
            state_d = ST_COMPLETE;
          end else begin
            wd_clear = 1'b1;
            state_d  = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        wd_en = 1'b1;
        if (rsp_done_i) begin
          state_d = ST_COMPLETE;
        end else if (wd_expire) begin
          wd_err_d = 1'b1;
          state_d  = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sw_rst_cmd_i) begin
      state_d    = ST_IDLE;
      sel_auto_d = 1'b0;
      sw_pend_d  = 1'b0;
      a12_pend_d = 1'b0;
      sw_slot_d  = '0;
      cmd_d      = '0;
      reject_d   = 1'b0;
      wd_err_d   = 1'b0;
      wd_clear   = 1'b1;
      wd_en      = 1'b0;
    end

    inhibit_d = sw_pend_d || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sel_auto_q <= 1'b0;
      sw_pend_q  <= 1'b0;
      a12_pend_q <= 1'b0;
      sw_slot_q  <= '0;
      cmd_q      <= '0;
      inhibit_q  <= 1'b0;
      reject_q   <= 1'b0;
      wd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_auto_q <= sel_auto_d;
      sw_pend_q  <= sw_pend_d;
      a12_pend_q <= a12_pend_d;
      sw_slot_q  <= sw_slot_d;
      cmd_q      <= cmd_d;
      inhibit_q  <= inhibit_d;
      reject_q   <= reject_d;
      wd_err_q   <= wd_err_d;
    end
  end

  assign cmd_start_o     = (state_q == ST_ISSUE);
  assign cmd_index_o     = cmd_q.index;
  assign cmd_arg_o       = cmd_q.arg;
  assign cmd_rsp_type_o  = cmd_q.rsp_type;
  assign cmd_inhibit_o   = inhibit_q;
  assign auto12_active_o = sel_auto_q && (state_q != ST_IDLE);
  assign sw_done_o       = (state_q == ST_COMPLETE) && !sel_auto_q;
  assign auto12_done_o   = (state_q == ST_COMPLETE) && sel_auto_q;
  assign sw_reject_o     = reject_q;
  assign watchdog_err_o  = wd_err_q;

endmodule

// File: tb/tb_cmd_issue_sched.sv
// Scenario bench for cmd_issue_sched: expected issued commands are queued at
// request time and popped when cmd_start_o appears.
module tb_cmd_issue_sched;

  localparam int unsigned WD = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sw_rst_cmd_i = 1'b0;
  logic        sw_req_i = 1'b0;
  logic [5:0]  sw_index_i = '0;
  logic [31:0] sw_arg_i = '0;
  logic [1:0]  sw_rsp_type_i = '0;
  logic        auto12_req_i = 1'b0;
  logic        cmd_sent_i = 1'b0;
  logic        rsp_done_i = 1'b0;
  logic        cmd_start_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_rsp_type_o;
  logic        cmd_inhibit_o;
  logic        auto12_active_o;
  logic        sw_done_o;
  logic        auto12_done_o;
  logic        sw_reject_o;
  logic        watchdog_err_o;

  cmd_issue_sched #(
    .WatchdogCycles(WD),
    .Auto12Index   (12)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sw_rst_cmd_i   (sw_rst_cmd_i),
    .sw_req_i       (sw_req_i),
    .sw_index_i     (sw_index_i),
    .sw_arg_i       (sw_arg_i),
    .sw_rsp_type_i  (sw_rsp_type_i),
    .auto12_req_i   (auto12_req_i),
    .cmd_start_o    (cmd_start_o),
    .cmd_index_o    (cmd_index_o),
    .cmd_arg_o      (cmd_arg_o),
    .cmd_rsp_type_o (cmd_rsp_type_o),
    .cmd_sent_i     (cmd_sent_i),
    .rsp_done_i     (rsp_done_i),
    .cmd_inhibit_o  (cmd_inhibit_o),
    .auto12_active_o(auto12_active_o),
    .sw_done_o      (sw_done_o),
    .auto12_done_o  (auto12_done_o),
    .sw_reject_o    (sw_reject_o),
    .watchdog_err_o (watchdog_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        auto12;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rsp;
  } exp_t;

  exp_t exp_q[$];

  logic [40:0] cmd_fields;
  logic [46:0] all_out;
  assign cmd_fields = {auto12_active_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o};
  assign all_out = {cmd_start_o, cmd_inhibit_o, auto12_active_o, sw_done_o, auto12_done_o,
                    sw_reject_o, watchdog_err_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o};

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int reject_cnt = 0;
  int err_cnt = 0;
  int b2b_cnt = 0;
  logic prev_start = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (cmd_start_o) start_cnt++;
    if (cmd_start_o && prev_start) b2b_cnt++;
    if (sw_done_o || auto12_done_o) done_cnt++;
    if (sw_reject_o) reject_cnt++;
    if (watchdog_err_o) err_cnt++;
    prev_start = cmd_start_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sw_request(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rsp,
                            input bit expect_issue, output int req_cyc);
    sw_req_i = 1'b1;
    sw_index_i = idx;
    sw_arg_i = arg;
    sw_rsp_type_i = rsp;
    req_cyc = cyc;
    if (expect_issue) exp_q.push_back('{1'b0, idx, arg, rsp});
    step();
    sw_req_i = 1'b0;
  endtask

  task automatic pulse_sent();
    cmd_sent_i = 1'b1;
    step();
    cmd_sent_i = 1'b0;
  endtask

  task automatic pulse_rsp();
    rsp_done_i = 1'b1;
    step();
    rsp_done_i = 1'b0;
  endtask

  task automatic wait_issue(output exp_t e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (cmd_start_o) break;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    $display("issue: cyc=%0d auto=%0b idx=%0d arg=%h rsp=%0d", cyc, cmd_start_o & auto12_active_o,
             cmd_index_o, cmd_arg_o, cmd_rsp_type_o);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    else passes++;
    rst_ni = 1'b1;
    step();
    checks++;
    if (all_out !== '0) $display("FAIL post_reset_idle got=%h exp=0", all_out);
    else passes++;
  endtask

  task automatic test_sw_cmd();
    int rc;
    exp_t e;
    step();
    sw_request(6'd17, 32'h0000_0200, 2'd2, 1'b1, rc);
    @(negedge clk_i);
    checks++;
    if ({cmd_inhibit_o, cmd_start_o} !== 2'b10)
      $display("FAIL sw_inhibit_capture got=%b exp=10", {cmd_inhibit_o, cmd_start_o});
    else passes++;
    wait_issue(e);
    checks++;
    if (cyc - rc != 2) $display("FAIL sw_latency got=%0d exp=2", cyc - rc);
    else passes++;
    checks++;
    if (cmd_fields !== e) $display("FAIL sw_fields got=%h exp=%h", cmd_fields, e);
    else passes++;
    step();
    pulse_sent();
    pulse_rsp();
    @(negedge clk_i);
    checks++;
    if ({sw_done_o, auto12_done_o} !== 2'b10)
      $display("FAIL sw_done got=%b exp=10", {sw_done_o, auto12_done_o});
    else passes++;
    step();
    @(negedge clk_i);
    checks++;
    if ({sw_done_o, cmd_inhibit_o} !== 2'b00)
      $display("FAIL sw_inhibit_clear got=%b exp=00", {sw_done_o, cmd_inhibit_o});
    else passes++;
  endtask

  task automatic test_simultaneous();
    int rc;
    int dc;
    exp_t e;
    step();
    auto12_req_i = 1'b1;
    exp_q.push_back('{1'b1, 6'd12, 32'h0, 2'd3});
    sw_request(6'd18, 32'h0000_1000, 2'd1, 1'b1, rc);
    auto12_req_i = 1'b0;
    wait_issue(e);
    checks++;
    if (cyc - rc != 2) $display("FAIL a12_latency got=%0d exp=2", cyc - rc);
    else passes++;
    checks++;
    if (cmd_fields !== e) $display("FAIL a12_first_fields got=%h exp=%h", cmd_fields, e);
    else passes++;
    step();
    pulse_sent();
    pulse_rsp();
    @(negedge clk_i);
    dc = cyc;
    checks++;
    if ({sw_done_o, auto12_done_o, cmd_inhibit_o} !== 3'b011)
      $display("FAIL a12_done got=%b exp=011", {sw_done_o, auto12_done_o, cmd_inhibit_o});
    else passes++;
    wait_issue(e);
    checks++;
    if (cyc - dc != 2) $display("FAIL sw_after_a12_gap got=%0d exp=2", cyc - dc);
    else passes++;
    checks++;
    if (cmd_fields !== e) $display("FAIL sw_second_fields got=%h exp=%h", cmd_fields, e);
    else passes++;
    step();
    pulse_sent();
    pulse_rsp();
    @(negedge clk_i);
    checks++;
    if ({sw_done_o, auto12_done_o} !== 2'b10)
      $display("FAIL sw_second_done got=%b exp=10", {sw_done_o, auto12_done_o});
    else passes++;
  endtask

  task automatic test_reject();
    int rc;
    int rc2;
    int sc;
    int b_start;
    int b_rej;
    int b_err;
    exp_t e;
    b_start = start_cnt;
    b_rej = reject_cnt;
    b_err = err_cnt;
    step();
    sw_request(6'd7, 32'h0000_00A5, 2'd0, 1'b1, rc);
    sw_request(6'd9, 32'h0000_00FF, 2'd2, 1'b0, rc2);
    wait_issue(e);
    checks++;
    if ({sw_reject_o, cmd_fields} !== {1'b1, e})
      $display("FAIL reject_pending got=%h exp=%h", {sw_reject_o, cmd_fields}, {1'b1, e});
    else passes++;
    step();
    sw_request(6'd10, 32'h0000_0011, 2'd0, 1'b0, rc2);
    @(negedge clk_i);
    checks++;
    if (sw_reject_o !== 1'b1) $display("FAIL reject_in_flight got=%b exp=1", sw_reject_o);
    else passes++;
    step();
    sc = cyc;
    pulse_sent();
    @(negedge clk_i);
    checks++;
    if ({sw_done_o, 32'(cyc - sc)} !== {1'b1, 32'd1})
      $display("FAIL no_rsp_done got=%b/%0d exp=1/1", sw_done_o, cyc - sc);
    else passes++;
    repeat (4) step();
    checks++;
    if ({start_cnt - b_start, reject_cnt - b_rej, err_cnt - b_err} !== {32'd1, 32'd2, 32'd0})
      $display("FAIL reject_counts got=%0d/%0d/%0d exp=1/2/0", start_cnt - b_start,
               reject_cnt - b_rej, err_cnt - b_err);
    else passes++;
  endtask

  task automatic test_auto12_merge();
    int b_start;
    int b_rej;
    exp_t e;
    b_start = start_cnt;
    b_rej = reject_cnt;
    step();
    auto12_req_i = 1'b1;
    exp_q.push_back('{1'b1, 6'd12, 32'h0, 2'd3});
    step();
    step();
    auto12_req_i = 1'b0;
    wait_issue(e);
    checks++;
    if (cmd_fields !== e) $display("FAIL merge_fields got=%h exp=%h", cmd_fields, e);
    else passes++;
    step();
    auto12_req_i = 1'b1;
    step();
    auto12_req_i = 1'b0;
    pulse_sent();
    pulse_rsp();
    @(negedge clk_i);
    checks++;
    if (auto12_done_o !== 1'b1) $display("FAIL merge_done got=%b exp=1", auto12_done_o);
    else passes++;
    repeat (5) step();
    checks++;
    if ({start_cnt - b_start, reject_cnt - b_rej} !== {32'd1, 32'd0})
      $display("FAIL merge_counts got=%0d/%0d exp=1/0", start_cnt - b_start, reject_cnt - b_rej);
    else passes++;
  endtask

  task automatic test_watchdog();
    int rc;
    int ec;
    int b_err;
    bit found;
    exp_t e;
    step();
    sw_request(6'd13, 32'h0000_0055, 2'd2, 1'b1, rc);
    wait_issue(e);
    checks++;
    if (cmd_fields !== e) $display("FAIL wd_fields got=%h exp=%h", cmd_fields, e);
    else passes++;
    step();
    pulse_sent();
    ec = cyc;
    b_err = err_cnt;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (watchdog_err_o) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || (cyc - ec != int'(WD)))
      $display("FAIL wd_expiry got=%0d(found=%0b) exp=%0d", cyc - ec, found, WD);
    else passes++;
    checks++;
    if (sw_done_o !== 1'b1) $display("FAIL wd_done got=%b exp=1", sw_done_o);
    else passes++;
    step();
    @(negedge clk_i);
    checks++;
    if ({cmd_inhibit_o, 32'(err_cnt - b_err)} !== {1'b0, 32'd1})
      $display("FAIL wd_after got=%b/%0d exp=0/1", cmd_inhibit_o, err_cnt - b_err);
    else passes++;

    step();
    sw_request(6'd14, 32'h0000_0066, 2'd3, 1'b1, rc);
    wait_issue(e);
    step();
    pulse_sent();
    b_err = err_cnt;
    repeat (WD - 1) step();
    pulse_rsp();
    @(negedge clk_i);
    checks++;
    if ({watchdog_err_o, sw_done_o, 32'(err_cnt - b_err)} !== {2'b01, 32'd0})
      $display("FAIL wd_rsp_wins got=%b%b/%0d exp=01/0", watchdog_err_o, sw_done_o, err_cnt - b_err);
    else passes++;
  endtask

  task automatic test_mid_reset(input bit use_async);
    int rc;
    int b_start;
    int b_done;
    exp_t e;
    step();
    sw_request(6'd24, 32'h0000_0077, 2'd2, 1'b1, rc);
    wait_issue(e);
    step();
    pulse_sent();
    auto12_req_i = 1'b1;
    step();
    auto12_req_i = 1'b0;
    b_start = start_cnt;
    b_done = done_cnt;
    if (use_async) begin
      rst_ni = 1'b0;
      #2;
    end else begin
      sw_rst_cmd_i = 1'b1;
      rsp_done_i = 1'b1;
      step();
      sw_rst_cmd_i = 1'b0;
      rsp_done_i = 1'b0;
    end
    checks++;
    if (all_out !== '0)
      $display("FAIL mid_reset_outputs(async=%0b) got=%h exp=0", use_async, all_out);
    else passes++;
    if (use_async) begin
      step();
      rst_ni = 1'b1;
    end
    step();
    pulse_rsp();
    repeat (4) step();
    checks++;
    if ({start_cnt - b_start, done_cnt - b_done} !== {32'd0, 32'd0})
      $display("FAIL mid_reset_quiet(async=%0b) got=%0d/%0d exp=0/0", use_async,
               start_cnt - b_start, done_cnt - b_done);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int rc;
    int b_rej;
    exp_t e;
    b_rej = reject_cnt;
    step();
    sw_request(6'd5, 32'h0000_0005, 2'd0, 1'b1, rc);
    wait_issue(e);
    step();
    pulse_sent();
    sw_req_i = 1'b1;
    sw_index_i = 6'd6;
    sw_arg_i = 32'h0000_0006;
    sw_rsp_type_i = 2'd0;
    rc = cyc;
    exp_q.push_back('{1'b0, 6'd6, 32'h0000_0006, 2'd0});
    @(negedge clk_i);
    checks++;
    if (sw_done_o !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", sw_done_o);
    else passes++;
    step();
    sw_req_i = 1'b0;
    wait_issue(e);
    checks++;
    if ({cmd_fields, 32'(cyc - rc)} !== {e, 32'd2})
      $display("FAIL b2b_second got=%h/%0d exp=%h/2", cmd_fields, cyc - rc, e);
    else passes++;
    step();
    pulse_sent();
    @(negedge clk_i);
    checks++;
    if ({sw_done_o, 32'(reject_cnt - b_rej), 32'(b2b_cnt)} !== {1'b1, 32'd0, 32'd0})
      $display("FAIL b2b_done got=%b/%0d/%0d exp=1/0/0", sw_done_o, reject_cnt - b_rej, b2b_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sw_cmd();
    test_simultaneous();
    test_reject();
    test_auto12_merge();
    test_watchdog();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
